// File: rtl/reg_cmd_pkg.sv
// ============================================================================
// reg_cmd_pkg : shared state encoding, command and status codes for reg_cmd_engine
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package reg_cmd_pkg;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ADDR      = 4'd1,
        VALUE     = 4'd2,
        CSUM      = 4'd3,
        EXEC_W    = 4'd4,
        EXEC_R    = 4'd5,
        WAIT_R    = 4'd6,
        RESP_STAT = 4'd7,
        RESP_DATA = 4'd8
    } state_t;

    localparam logic [7:0] CMD_PING  = 8'h00;
    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_READ  = 8'h02;
    localparam logic [7:0] CMD_WRRD  = 8'h03;

    localparam logic [7:0] ST_OK       = 8'h00;
    localparam logic [7:0] ST_BADSUM   = 8'h01;
    localparam logic [7:0] ST_BADCMD   = 8'h02;
    localparam logic [7:0] ST_RTIMEOUT = 8'h03;

    // Bit offset of the idx-th word on the wire inside an n_words-wide vector.
    function automatic int unsigned word_lsb(input int unsigned idx, input int unsigned n_words,
                                             input int unsigned width, input bit le);
        return (le ? idx : (n_words - 1 - idx)) * width;
    endfunction

endpackage

`default_nettype wire

// File: rtl/gap_timer.sv
// ============================================================================
// gap_timer : reloadable down-counter; expired while enabled and at zero
// Revision  : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module gap_timer #(
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_enable,
    output logic             o_expired
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_enable && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_expired = i_enable && (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/reg_cmd_engine.sv
// ============================================================================
// reg_cmd_engine : variable-length checksummed command parser driving a register block
// Revision       : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module reg_cmd_engine
    import reg_cmd_pkg::*;
#(
    parameter int WORD_WIDTH    = 8,
    parameter int VALUE_WORDS   = 4,
    parameter int ADDR_WORDS    = 1,
    parameter int LITTLE_ENDIAN = 0,
    parameter int GAP_CYCLES    = 100000,
    parameter int READ_TIMEOUT  = 16
) (
    input  logic                              clk,
    input  logic                              i_reset,
    input  logic [WORD_WIDTH-1:0]             i_data,
    input  logic                              i_dv,
    output logic                              o_w_en,
    output logic                              o_r_en,
    output logic [WORD_WIDTH*ADDR_WORDS-1:0]  o_addr,
    output logic [WORD_WIDTH*VALUE_WORDS-1:0] o_value,
    input  logic [WORD_WIDTH*VALUE_WORDS-1:0] i_r_value,
    input  logic                              i_r_valid,
    input  logic                              i_tx_ready,
    output logic [WORD_WIDTH-1:0]             o_data,
    output logic                              o_dv,
    output logic                              o_busy,
    output logic [7:0]                        o_err_count
);

    localparam int c_ADDR_W = WORD_WIDTH * ADDR_WORDS;
    localparam int c_VAL_W  = WORD_WIDTH * VALUE_WORDS;
    localparam int c_GAP_W  = $clog2(GAP_CYCLES + 1);
    localparam int c_RD_W   = $clog2(READ_TIMEOUT + 1);
    localparam logic [c_GAP_W-1:0] c_GAP_LOAD = c_GAP_W'(GAP_CYCLES);
    localparam logic [c_RD_W-1:0]  c_RD_LOAD  = c_RD_W'(READ_TIMEOUT - 1);
    localparam bit c_LE = (LITTLE_ENDIAN != 0);

    state_t                  r_state, w_next_state;
    logic [WORD_WIDTH-1:0]   r_cmd, r_csum, r_status;
    logic [7:0]              r_cnt, r_err_count;
    logic [c_ADDR_W-1:0]     r_addr;
    logic [c_VAL_W-1:0]      r_value, r_rdata;
    logic                    w_gap_run, w_busy, w_accept, w_cmd_known, w_is_write, w_is_read;
    logic                    w_has_data, w_gap_expired, w_rd_expired, w_err_inc;
    int unsigned             w_addr_lsb, w_val_lsb;

    assign w_gap_run   = (r_state == ADDR) || (r_state == VALUE) || (r_state == CSUM);
    assign w_busy      = (r_state != IDLE) && !w_gap_run;
    assign w_accept    = i_dv && !w_busy;
    assign w_cmd_known = (i_data == WORD_WIDTH'(CMD_PING))  || (i_data == WORD_WIDTH'(CMD_WRITE)) ||
                         (i_data == WORD_WIDTH'(CMD_READ))  || (i_data == WORD_WIDTH'(CMD_WRRD));
    assign w_is_write  = (r_cmd == WORD_WIDTH'(CMD_WRITE)) || (r_cmd == WORD_WIDTH'(CMD_WRRD));
    assign w_is_read   = (r_cmd == WORD_WIDTH'(CMD_READ))  || (r_cmd == WORD_WIDTH'(CMD_WRRD));
    // A read-timeout response still carries its (zeroed) data words.
    assign w_has_data  = w_is_read && ((r_status == WORD_WIDTH'(ST_OK)) ||
                                       (r_status == WORD_WIDTH'(ST_RTIMEOUT)));
    assign w_addr_lsb  = word_lsb(32'(r_cnt), 32'(ADDR_WORDS), 32'(WORD_WIDTH), c_LE);
    assign w_val_lsb   = word_lsb(32'(r_cnt), 32'(VALUE_WORDS), 32'(WORD_WIDTH), c_LE);

    gap_timer #(.WIDTH(c_GAP_W)) u_gap_timer (
        .clk          (clk),
        .i_reset      (i_reset),
        .i_load       (w_accept),
        .i_load_value (c_GAP_LOAD),
        .i_enable     (w_gap_run),
        .o_expired    (w_gap_expired)
    );

    gap_timer #(.WIDTH(c_RD_W)) u_read_timer (
        .clk          (clk),
        .i_reset      (i_reset),
        .i_load       (r_state == EXEC_R),
        .i_load_value (c_RD_LOAD),
        .i_enable     (r_state == WAIT_R),
        .o_expired    (w_rd_expired)
    );

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) r_state <= IDLE;
        else         r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_err_inc    = 1'b0;
        o_w_en       = 1'b0;
        o_r_en       = 1'b0;
        o_dv         = 1'b0;
        o_data       = '0;
        case (r_state)
            IDLE: if (w_accept) begin
                if (w_cmd_known) begin
                    w_next_state = ADDR;
                end else begin
                    w_next_state = RESP_STAT;
                    w_err_inc    = 1'b1;
                end
            end
            ADDR: if (w_accept) begin
                if (r_cnt == 8'(ADDR_WORDS - 1)) w_next_state = w_is_write ? VALUE : CSUM;
            end else if (w_gap_expired) begin
                w_next_state = IDLE;
                w_err_inc    = 1'b1;
            end
            VALUE: if (w_accept) begin
                if (r_cnt == 8'(VALUE_WORDS - 1)) w_next_state = CSUM;
            end else if (w_gap_expired) begin
                w_next_state = IDLE;
                w_err_inc    = 1'b1;
            end
            CSUM: if (w_accept) begin
                if (i_data != r_csum) begin
                    w_next_state = RESP_STAT;
                    w_err_inc    = 1'b1;
                end else if (w_is_write) begin
                    w_next_state = EXEC_W;
                end else if (w_is_read) begin
                    w_next_state = EXEC_R;
                end else begin
                    w_next_state = RESP_STAT;
                end
            end else if (w_gap_expired) begin
                w_next_state = IDLE;
                w_err_inc    = 1'b1;
            end
            EXEC_W: begin
                o_w_en       = 1'b1;
                w_next_state = w_is_read ? EXEC_R : RESP_STAT;
            end
            EXEC_R: begin
                o_r_en       = 1'b1;
                w_next_state = WAIT_R;
            end
            WAIT_R: if (i_r_valid) begin
                w_next_state = RESP_STAT;
            end else if (w_rd_expired) begin
                w_next_state = RESP_STAT;
                w_err_inc    = 1'b1;
            end
            RESP_STAT: if (i_tx_ready) begin
                o_dv         = 1'b1;
                o_data       = r_status;
                w_next_state = w_has_data ? RESP_DATA : IDLE;
            end
            RESP_DATA: if (i_tx_ready) begin
                o_dv   = 1'b1;
                o_data = r_rdata[w_val_lsb +: WORD_WIDTH];
                if (r_cnt == 8'(VALUE_WORDS - 1)) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            r_cmd       <= '0;
            r_csum      <= '0;
            r_status    <= '0;
            r_cnt       <= '0;
            r_err_count <= '0;
            r_addr      <= '0;
            r_value     <= '0;
            r_rdata     <= '0;
        end else begin
            if (w_err_inc && (r_err_count != 8'hFF)) r_err_count <= r_err_count + 8'd1;
            case (r_state)
                IDLE: if (w_accept) begin
                    r_cmd  <= i_data;
                    r_csum <= i_data;
                    r_cnt  <= '0;
                    if (!w_cmd_known) r_status <= WORD_WIDTH'(ST_BADCMD);
                end
                ADDR: if (w_accept) begin
                    r_csum                             <= r_csum ^ i_data;
                    r_addr[w_addr_lsb +: WORD_WIDTH]   <= i_data;
                    r_cnt <= (r_cnt == 8'(ADDR_WORDS - 1)) ? 8'd0 : r_cnt + 8'd1;
                end
                VALUE: if (w_accept) begin
                    r_csum                             <= r_csum ^ i_data;
                    r_value[w_val_lsb +: WORD_WIDTH]   <= i_data;
                    r_cnt <= (r_cnt == 8'(VALUE_WORDS - 1)) ? 8'd0 : r_cnt + 8'd1;
                end
                CSUM: if (w_accept) begin
                    r_status <= (i_data == r_csum) ? WORD_WIDTH'(ST_OK) : WORD_WIDTH'(ST_BADSUM);
                end
                WAIT_R: if (i_r_valid) begin
                    r_rdata  <= i_r_value;
                    r_status <= WORD_WIDTH'(ST_OK);
                end else if (w_rd_expired) begin
                    r_rdata  <= '0;
                    r_status <= WORD_WIDTH'(ST_RTIMEOUT);
                end
                RESP_STAT: r_cnt <= '0;
                RESP_DATA: if (i_tx_ready) r_cnt <= r_cnt + 8'd1;
                default: ;
            endcase
        end
    end

    assign o_addr      = r_addr;
    assign o_value     = r_value;
    assign o_busy      = w_busy;
    assign o_err_count = r_err_count;

endmodule

`default_nettype wire

// File: tb/tb_reg_cmd_engine.sv
// ============================================================================
// tb_reg_cmd_engine : directed frames against big- and little-endian engines
// Revision          : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_reg_cmd_engine;

    localparam int c_GAP = 40;

    logic        clk = 1'b0;
    logic        i_reset, i_dv, i_r_valid, i_tx_ready;
    logic [7:0]  i_data;
    logic [31:0] i_r_value;

    logic        dut_w_en, dut_r_en, dut_dv, dut_busy;
    logic [7:0]  dut_addr, dut_data, dut_err;
    logic [31:0] dut_value;
    logic        le_w_en, le_r_en, le_dv, le_busy;
    logic [7:0]  le_addr, le_data, le_err;
    logic [31:0] le_value;

    logic [7:0]  rsp_q[$];
    logic [7:0]  rsp_le_q[$];
    int          w_en_cnt = 0, r_en_cnt = 0, rd_pend = 0, rd_delay = 3;
    logic [31:0] model_value = 32'h0;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    reg_cmd_engine #(.GAP_CYCLES(c_GAP)) dut (
        .clk(clk), .i_reset(i_reset), .i_data(i_data), .i_dv(i_dv),
        .o_w_en(dut_w_en), .o_r_en(dut_r_en), .o_addr(dut_addr), .o_value(dut_value),
        .i_r_value(i_r_value), .i_r_valid(i_r_valid), .i_tx_ready(i_tx_ready),
        .o_data(dut_data), .o_dv(dut_dv), .o_busy(dut_busy), .o_err_count(dut_err)
    );

    reg_cmd_engine #(.GAP_CYCLES(c_GAP), .LITTLE_ENDIAN(1)) dut_le (
        .clk(clk), .i_reset(i_reset), .i_data(i_data), .i_dv(i_dv),
        .o_w_en(le_w_en), .o_r_en(le_r_en), .o_addr(le_addr), .o_value(le_value),
        .i_r_value(i_r_value), .i_r_valid(i_r_valid), .i_tx_ready(i_tx_ready),
        .o_data(le_data), .o_dv(le_dv), .o_busy(le_busy), .o_err_count(le_err)
    );

    always @(negedge clk) begin
        if (dut_dv) rsp_q.push_back(dut_data);
        if (le_dv)  rsp_le_q.push_back(le_data);
        if (dut_w_en) w_en_cnt++;
        if (dut_r_en) begin
            r_en_cnt++;
            rd_pend = rd_delay;
        end
    end

    // Register block model: answers rd_delay cycles after the read strobe (0 = never).
    initial begin
        i_r_valid = 1'b0;
        i_r_value = 32'hFFFF_FFFF;
        forever begin
            @(posedge clk);
            #1;
            i_r_valid = 1'b0;
            i_r_value = 32'hFFFF_FFFF;
            if (rd_pend == 1) begin
                i_r_valid = 1'b1;
                i_r_value = model_value;
            end
            if (rd_pend > 0) rd_pend--;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int n, input logic [63:0] bytes);
        for (int i = 0; i < n; i++) begin
            i_data = bytes[(n-1-i)*8 +: 8];
            i_dv   = 1'b1;
            tick();
        end
        i_dv   = 1'b0;
        i_data = 8'h00;
    endtask

    task automatic wait_rsp(input int n, input int budget);
        int b;
        b = budget;
        while ((rsp_q.size() < n) && (b > 0)) begin
            tick();
            b--;
        end
        repeat (8) tick();
    endtask

    task automatic expect_rsp(input string tag, input int n, input logic [63:0] exp, input bit le);
        logic [63:0] got;
        int          sz;
        got = '0;
        sz  = le ? rsp_le_q.size() : rsp_q.size();
        for (int i = 0; i < sz && i < 8; i++) got = {got[55:0], (le ? rsp_le_q[i] : rsp_q[i])};
        check({tag, "_len"}, 64'(sz), 64'(n));
        check(tag, got, exp);
    endtask

    task automatic clear_rsp();
        rsp_q.delete();
        rsp_le_q.delete();
    endtask

    initial begin
        i_reset    = 1'b1;
        i_dv       = 1'b0;
        i_data     = 8'h00;
        i_tx_ready = 1'b1;
        repeat (3) tick();
        check("rst_dv",   64'(dut_dv),   64'd0);
        check("rst_data", 64'(dut_data), 64'd0);
        check("rst_wen",  64'(dut_w_en), 64'd0);
        check("rst_ren",  64'(dut_r_en), 64'd0);
        check("rst_addr", 64'(dut_addr), 64'd0);
        check("rst_val",  64'(dut_value), 64'd0);
        check("rst_busy", 64'(dut_busy), 64'd0);
        check("rst_err",  64'(dut_err),  64'd0);
        i_reset = 1'b0;
        tick();

        // Write: strobe one cycle after CSUM, status two cycles after.
        send(7, 64'h01_05_DEADBEEF_26);
        check("wr_strobe", 64'(dut_w_en), 64'd1);
        check("wr_addr",   64'(dut_addr), 64'h05);
        check("wr_value",  64'(dut_value), 64'hDEADBEEF);
        check("wr_value_le", 64'(le_value), 64'hEFBEADDE);
        tick();
        check("wr_latency", 64'({dut_dv, dut_data}), 64'h100);
        wait_rsp(1, 50);
        expect_rsp("wr_rsp", 1, 64'h00, 1'b0);
        check("wr_count", 64'(w_en_cnt), 64'd1);
        clear_rsp();

        // Read, answered 3 cycles after the read strobe.
        model_value = 32'hDEADBEEF;
        rd_delay    = 3;
        send(3, 64'h02_05_07);
        wait_rsp(5, 100);
        expect_rsp("rd_rsp",    5, 64'h00_DEADBEEF, 1'b0);
        expect_rsp("rd_rsp_le", 5, 64'h00_EFBEADDE, 1'b1);
        check("rd_count", 64'(r_en_cnt), 64'd1);
        clear_rsp();

        // Bad checksum.
        send(7, 64'h01_05_DEADBEEF_27);
        wait_rsp(1, 50);
        expect_rsp("badsum_rsp", 1, 64'h01, 1'b0);
        check("badsum_nowr", 64'(w_en_cnt), 64'd1);
        check("badsum_err",  64'(dut_err),  64'd1);
        clear_rsp();

        // Gap timeout after GAP+1 idle cycles.
        send(2, 64'h02_05);
        repeat (c_GAP + 1) tick();
        check("gap_err",   64'(dut_err),      64'd2);
        check("gap_nord",  64'(r_en_cnt),     64'd1);
        check("gap_norsp", 64'(rsp_q.size()), 64'd0);
        check("gap_idle",  64'(dut_busy),     64'd0);

        // Exactly GAP idle cycles between bytes is still inside the frame.
        model_value = 32'h12345678;
        send(1, 64'h02);
        repeat (c_GAP) tick();
        send(2, 64'h05_07);
        wait_rsp(5, 100);
        expect_rsp("gap_edge_rsp", 5, 64'h00_12345678, 1'b0);
        check("gap_edge_err", 64'(dut_err), 64'd2);
        clear_rsp();

        // Backpressure in the middle of a read response.
        model_value = 32'hA5C30F96;
        send(3, 64'h02_05_07);
        for (int b = 0; (b < 100) && (rsp_q.size() < 2); b++) tick();
        i_tx_ready = 1'b0;
        repeat (10) tick();
        check("bp_hold", 64'(rsp_q.size()), 64'd2);
        i_tx_ready = 1'b1;
        wait_rsp(5, 50);
        expect_rsp("bp_rsp", 5, 64'h00_A5C30F96, 1'b0);
        clear_rsp();

        // Read timeout: register block never answers.
        rd_delay = 0;
        send(3, 64'h02_05_07);
        wait_rsp(5, 100);
        expect_rsp("rto_rsp", 5, 64'h03_00000000, 1'b0);
        check("rto_err", 64'(dut_err), 64'd3);
        clear_rsp();

        // Unknown command, then a ping parsed as a fresh frame.
        send(1, 64'h7F);
        wait_rsp(1, 50);
        expect_rsp("badcmd_rsp", 1, 64'h02, 1'b0);
        check("badcmd_err", 64'(dut_err), 64'd4);
        clear_rsp();
        send(3, 64'h00_05_05);
        wait_rsp(1, 50);
        expect_rsp("ping_rsp", 1, 64'h00, 1'b0);
        check("ping_noacc", 64'(w_en_cnt + r_en_cnt), 64'd5);
        clear_rsp();

        // Reset between response words.
        rd_delay    = 3;
        model_value = 32'h11223344;
        send(3, 64'h02_05_07);
        for (int b = 0; (b < 100) && (rsp_q.size() < 1); b++) tick();
        i_reset = 1'b1;
        repeat (5) tick();
        check("rstmid_words", 64'(rsp_q.size()), 64'd1);
        check("rstmid_dv",    64'(dut_dv),    64'd0);
        check("rstmid_data",  64'(dut_data),  64'd0);
        check("rstmid_addr",  64'(dut_addr),  64'd0);
        check("rstmid_val",   64'(dut_value), 64'd0);
        check("rstmid_err",   64'(dut_err),   64'd0);
        check("rstmid_busy",  64'(dut_busy),  64'd0);
        i_reset = 1'b0;
        tick();
        clear_rsp();
        send(3, 64'h00_05_05);
        wait_rsp(1, 50);
        expect_rsp("post_rst_ping", 1, 64'h00, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
